// File: rtl/calc_btn_pkg.sv
// Shared types and button indices for the calculator button conditioner.
package calc_btn_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_RISE = 2'b01,
    S_HIGH = 2'b10,
    S_FALL = 2'b11
  } btn_state_t;

  localparam int NUM_BTN = 5;
  localparam int BTN_C   = 0;
  localparam int BTN_U   = 1;
  localparam int BTN_L   = 2;
  localparam int BTN_R   = 3;
  localparam int BTN_D   = 4;

endpackage

// File: rtl/calc_btn_debounce.sv
// One button lane: synchronizer, 4-state debounce FSM with saturating counter,
// registered level and one-cycle rise strobe.
import calc_btn_pkg::*;

module calc_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic high
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CW-1:0]          cnt;
  btn_state_t             state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync <= '0;
    else         sync <= {sync[SYNC_STAGES-2:0], raw};
  end

  assign s    = sync[SYNC_STAGES-1];
  assign high = (state == S_HIGH);

  // level/pulse are updated on the same edge as the state they reflect
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_LOW;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      unique case (state)
        S_LOW: if (s) begin
          cnt   <= '0;
          state <= S_RISE;
        end
        S_RISE: begin
          if (!s) state <= S_LOW;
          else if (cnt == CNT_MAX) begin
            state <= S_HIGH;
            level <= 1'b1;
            pulse <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        S_HIGH: if (!s) begin
          cnt   <= '0;
          state <= S_FALL;
        end
        S_FALL: begin
          if (s) state <= S_HIGH;
          else if (cnt == CNT_MAX) begin
            state <= S_LOW;
            level <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= S_LOW;
      endcase
    end
  end

endmodule

// File: rtl/calc_btn_cond.sv
// Conditions the five board buttons: levels for l/r/d, press strobes for c/u.
// Optional btnc auto-repeat when CALC_BTN_AUTOREPEAT_EN is defined.
import calc_btn_pkg::*;

module calc_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic btnc_raw,
  input  logic btnu_raw,
  input  logic btnl_raw,
  input  logic btnr_raw,
  input  logic btnd_raw,
  output logic btnl,
  output logic btnr,
  output logic btnd,
  output logic btnc_pulse,
  output logic btnu_pulse
);

  logic [NUM_BTN-1:0] raw, level, pulse, high;

  assign raw = {btnd_raw, btnr_raw, btnl_raw, btnu_raw, btnc_raw};

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    calc_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_db (
      .clk   (clk),
      .resetn(resetn),
      .raw   (raw[b]),
      .level (level[b]),
      .pulse (pulse[b]),
      .high  (high[b])
    );
  end

  assign btnl       = level[BTN_L];
  assign btnr       = level[BTN_R];
  assign btnd       = level[BTN_D];
  assign btnu_pulse = pulse[BTN_U];

`ifdef CALC_BTN_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  logic [RW-1:0] rcnt;
  logic          rep;

  // Counter restarts on the press edge (state was S_RISE) and on any exit from S_HIGH
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rcnt <= '0;
      rep  <= 1'b0;
    end else if (!high[BTN_C]) begin
      rcnt <= '0;
      rep  <= 1'b0;
    end else if (rcnt == RW'(REPEAT_CYCLES - 1)) begin
      rcnt <= '0;
      rep  <= 1'b1;
    end else begin
      rcnt <= rcnt + 1'b1;
      rep  <= 1'b0;
    end
  end

  assign btnc_pulse = pulse[BTN_C] | rep;
`else
  assign btnc_pulse = pulse[BTN_C];
`endif

  logic unused_sig;
  assign unused_sig = ^{level[BTN_U:BTN_C], pulse[BTN_D:BTN_L], high, (REPEAT_CYCLES > 0)};

endmodule

// File: tb/tb_calc_btn_cond.sv
// Self-checking bench for calc_btn_cond with a run-length reference model.
module tb_calc_btn_cond;

  localparam int D    = 4;
  localparam int SYNC = 2;
  localparam int R    = 10;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [4:0] raw = '0;
  logic btnl, btnr, btnd, btnc_pulse, btnu_pulse;

  int checks = 0;
  int failures = 0;

  calc_btn_cond #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(SYNC), .REPEAT_CYCLES(R)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .btnc_raw  (raw[0]),
    .btnu_raw  (raw[1]),
    .btnl_raw  (raw[2]),
    .btnr_raw  (raw[3]),
    .btnd_raw  (raw[4]),
    .btnl      (btnl),
    .btnr      (btnr),
    .btnd      (btnd),
    .btnc_pulse(btnc_pulse),
    .btnu_pulse(btnu_pulse)
  );

  always #5 clk = ~clk;

  // Reference: the debounced value flips once the synchronized input has held
  // a new value for D+1 consecutive samples; the synchronized input is the raw
  // sample taken SYNC edges earlier.
  logic [4:0] rawq[$];
  logic [4:0] ms, last_s, m_lvl, m_pulse;
  int         run[5];
  logic       m_rep, hi;
  int         since;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rawq.delete();
      for (int i = 0; i < SYNC; i++) rawq.push_back('0);
      last_s = '0; m_lvl = '0; m_pulse = '0;
      for (int b = 0; b < 5; b++) run[b] = 0;
      m_rep = 1'b0; hi = 1'b0; since = 0;
    end else begin
      rawq.push_back(raw);
      ms = rawq.pop_front();
      for (int b = 0; b < 5; b++) begin
        if (ms[b] == last_s[b]) run[b] = (run[b] > 1000) ? run[b] : run[b] + 1;
        else run[b] = 1;
        m_pulse[b] = 1'b0;
        if (ms[b] != m_lvl[b] && run[b] >= D + 1) begin
          m_lvl[b]   = ms[b];
          m_pulse[b] = ms[b];
        end
      end
      last_s = ms;
      m_rep = 1'b0;
`ifdef CALC_BTN_AUTOREPEAT_EN
      if (m_pulse[0]) since = 0;
      else if (hi) begin
        since++;
        if (since == R) begin m_rep = 1'b1; since = 0; end
      end else since = 0;
      hi = m_lvl[0] && ms[0];
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    int first, npulse;
    resetn = 1'b0;
    raw = 5'b00001;
    settle(3);
    checks++; if (btnl !== 1'b0) begin failures++; $display("FAIL reset_btnl got=%b exp=0", btnl); end
    checks++; if (btnr !== 1'b0) begin failures++; $display("FAIL reset_btnr got=%b exp=0", btnr); end
    checks++; if (btnd !== 1'b0) begin failures++; $display("FAIL reset_btnd got=%b exp=0", btnd); end
    checks++; if (btnc_pulse !== 1'b0) begin failures++; $display("FAIL reset_btnc_pulse got=%b exp=0", btnc_pulse); end
    checks++; if (btnu_pulse !== 1'b0) begin failures++; $display("FAIL reset_btnu_pulse got=%b exp=0", btnu_pulse); end
    // btnc held through release counts as a fresh press
    resetn = 1'b1;
    first = 0; npulse = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (btnc_pulse === 1'b1) begin npulse++; if (first == 0) first = k; end
    end
    checks++; if (first !== 7) begin failures++; $display("FAIL held_through_reset_edge got=%0d exp=7", first); end
    checks++; if (npulse !== 1) begin failures++; $display("FAIL held_through_reset_count got=%0d exp=1", npulse); end
    raw = '0;
    settle(12);
  endtask

  task automatic test_level_latency();
    raw[2] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++; if (btnl !== (k >= 7)) begin failures++; $display("FAIL latency_btnl edge=%0d got=%b exp=%b", k, btnl, k >= 7); end
      checks++; if ({btnr, btnd} !== 2'b00) begin failures++; $display("FAIL latency_others edge=%0d got=%b exp=00", k, {btnr, btnd}); end
    end
    raw = '0;
    settle(12);
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 24; k++) begin
      raw[0] = (k < 8) ? ~k[1] : 1'b0;
      tick();
      checks++; if (btnc_pulse !== 1'b0) begin failures++; $display("FAIL bounce_btnc_pulse cyc=%0d got=%b exp=0", k, btnc_pulse); end
    end
  endtask

  task automatic test_press();
    int npulse, exp_n;
    logic exp;
    npulse = 0;
    raw[0] = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      exp = (k == 7);
`ifdef CALC_BTN_AUTOREPEAT_EN
      exp = exp || (k > 7 && (k - 7) % R == 0);
`endif
      if (btnc_pulse === 1'b1) npulse++;
      checks++; if (btnc_pulse !== exp) begin failures++; $display("FAIL press_btnc_pulse edge=%0d got=%b exp=%b", k, btnc_pulse, exp); end
    end
`ifdef CALC_BTN_AUTOREPEAT_EN
    exp_n = 5;
`else
    exp_n = 1;
`endif
    checks++; if (npulse !== exp_n) begin failures++; $display("FAIL press_pulse_count got=%0d exp=%0d", npulse, exp_n); end
    raw = '0;
    settle(12);
  endtask

  task automatic test_simultaneous();
    int pu, pd;
    pu = 0; pd = 0;
    raw[1] = 1'b1; raw[4] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (btnu_pulse === 1'b1 && pu == 0) pu = k;
      if (btnd === 1'b1 && pd == 0) pd = k;
    end
    checks++; if (pu !== 7) begin failures++; $display("FAIL simul_btnu_edge got=%0d exp=7", pu); end
    checks++; if (pd !== pu) begin failures++; $display("FAIL simul_btnd_vs_btnu got=%0d exp=%0d", pd, pu); end
    raw = '0;
    settle(12);
  endtask

  task automatic test_reset_abort();
    raw[3] = 1'b1;
    settle(5);
    resetn = 1'b0;
    #1;
    checks++; if ({btnr, btnc_pulse, btnu_pulse} !== 3'b000) begin failures++; $display("FAIL abort_in_reset got=%b exp=000", {btnr, btnc_pulse, btnu_pulse}); end
    tick();
    resetn = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++; if (btnr !== (k >= 7)) begin failures++; $display("FAIL abort_redebounce edge=%0d got=%b exp=%b", k, btnr, k >= 7); end
      checks++; if ({btnc_pulse, btnu_pulse} !== 2'b00) begin failures++; $display("FAIL abort_no_pulse edge=%0d got=%b exp=00", k, {btnc_pulse, btnu_pulse}); end
    end
    raw = '0;
    settle(12);
  endtask

  task automatic test_glitch();
    raw[4] = 1'b1;
    settle(10);
    checks++; if (btnd !== 1'b1) begin failures++; $display("FAIL glitch_btnd_high got=%b exp=1", btnd); end
    raw[4] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) raw[4] = 1'b1;
      tick();
      checks++; if (btnd !== 1'b1) begin failures++; $display("FAIL glitch_btnd_held cyc=%0d got=%b exp=1", k, btnd); end
    end
    raw[4] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++; if (btnd !== (k < 7)) begin failures++; $display("FAIL glitch_btnd_fall edge=%0d got=%b exp=%b", k, btnd, k < 7); end
    end
    settle(4);
  endtask

  task automatic test_random();
    logic exp_c;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 5) == 0) raw[b] = ~raw[b];
      resetn = ($urandom_range(0, 249) != 0);
      tick();
      exp_c = m_pulse[0] | m_rep;
      checks++; if (btnl !== m_lvl[2]) begin failures++; $display("FAIL rand_btnl cyc=%0d got=%b exp=%b", i, btnl, m_lvl[2]); end
      checks++; if (btnr !== m_lvl[3]) begin failures++; $display("FAIL rand_btnr cyc=%0d got=%b exp=%b", i, btnr, m_lvl[3]); end
      checks++; if (btnd !== m_lvl[4]) begin failures++; $display("FAIL rand_btnd cyc=%0d got=%b exp=%b", i, btnd, m_lvl[4]); end
      checks++; if (btnc_pulse !== exp_c) begin failures++; $display("FAIL rand_btnc_pulse cyc=%0d got=%b exp=%b", i, btnc_pulse, exp_c); end
      checks++; if (btnu_pulse !== m_pulse[1]) begin failures++; $display("FAIL rand_btnu_pulse cyc=%0d got=%b exp=%b", i, btnu_pulse, m_pulse[1]); end
    end
    resetn = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_level_latency();
    test_bounce();
    test_press();
    test_simultaneous();
    test_reset_abort();
    test_glitch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
